apa102_frame_reader: RTL
========================

Name: apa102_frame_reader

Overview:
- Reader side of the pixel frame buffer: the read port of the simple dual-port frame RAM is owned by this block.
- On a start pulse, fetches NUM_LEDS 24-bit pixel words from the RAM in address order and serialises them as one APA102 frame: start frame, one LED frame per pixel, end frame.
- Drives the LED strip pins sck/sdo directly.
- Runs entirely in the RAM read-clock domain.

Parameters:
- NUM_LEDS, 64, number of pixels per frame; equals the frame RAM DEPTH; minimum 1.
- CLK_DIV, 4, clk cycles per sck phase; bit period = 2*CLK_DIV cycles; minimum 1.
- END_BITS, ((NUM_LEDS+15)/16)*8, number of '1' bits in the end frame.

Ports:
- clk  input  1  system clock; also drives the RAM rclk.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  one-cycle pulse; begins a frame when idle.
- brightness  input  5  global brightness; sampled on an accepted start.
- raddr  output  $clog2(NUM_LEDS)  registered RAM read address.
- read_data  input  24  RAM read data {R[23:16],G[15:8],B[7:0]}; valid on the second clk edge after raddr changes (RAM registers raddr, then the data).
- sck  output  1  APA102 clock; idles low.
- sdo  output  1  APA102 data, MSB first.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; sck=0, sdo=0, busy=0, done=0, raddr=0. Applies mid-frame too; the frame is abandoned with no end frame, and the next frame starts from scratch.
- States: IDLE -> START_FR -> LED_FR (NUM_LEDS times) -> END_FR -> IDLE.
- IDLE:
  - start=1 is accepted, brightness is latched, raddr<=0, and the state goes to START_FR next cycle.
  - start while busy is ignored, with no queuing.
- Bit timing:
  - Each bit: sdo is set to the new value at phase start with sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles.
  - sdo is stable across every sck rising edge.
  - No idle gaps between bits or frames; sck runs continuously while busy.
- START_FR: 32 bits of 0.
- LED_FR word for pixel i: {3'b111, brightness_latched, B, G, R}, 32 bits, MSB first.
- Prefetch:
  - At bit 0 of START_FR and of each LED frame i, raddr is already set to the next pixel's address. Data is captured into a 24-bit holding register 2 cycles later, which is well before the word ends for any CLK_DIV>=1.
  - raddr increments once per LED frame and holds after NUM_LEDS-1; no wrap mid-frame.
- END_FR: END_BITS bits of 1.
- Completion:
  - After the final high phase: done=1 for exactly one cycle, busy=0 in that same cycle, sck=0, sdo=0, state=IDLE.
  - start in the done cycle is accepted.
- Totals:
  - Total sck rising edges per frame = 32 + 32*NUM_LEDS + END_BITS.
  - busy duration = 2*CLK_DIV*(that total) cycles.
- Counters: the bit counter is wide enough for max(32, END_BITS); the LED counter is $clog2(NUM_LEDS+1) bits.
- RAM contents changing mid-frame: whatever value is read at fetch time is sent. Tearing is acceptable and is the writer's concern.

Test Plan:
- NUM_LEDS=2, CLK_DIV=2, RAM[0]=24'hFF0000, RAM[1]=24'h00FF80, brightness=5'h1F, start -> sampled on sck rises: 32x'0', then 0xFF0000FF, then 0xFF80FF00, then 8x'1'. 104 sck rises total, busy high 416 cycles, done pulse once.
- Same setup, brightness=5'h03 -> LED words 0xE30000FF and 0xE380FF00.
- raddr monitor -> values 0 then 1 only, each change at least 2 cycles before its word's first bit; raddr holds at 1 through END_FR.
- start pulsed at cycle 50 of busy -> ignored; exactly one frame, bit counts unchanged; start on the done cycle -> second identical frame begins with no gap cycle beyond 1.
- rst_n=0 for 1 cycle at cycle 200 of a frame -> next cycle sck=0, sdo=0, busy=0, done=0, raddr=0; a subsequent start yields a complete, correct frame.
- CLK_DIV=1, NUM_LEDS=64 with RAM[i]={i,~i,i} -> all 64 words correct (prefetch meets the 64-cycle word time); 32+2048+32 sck rises.

Source files
------------

// File: rtl/apa102_frame_reader_if.sv
// Control handshake between a frame requester and the APA102 frame reader.
// The requester pulses start and watches busy/done.
interface apa102_frame_reader_if;
    logic       start;
    logic [4:0] brightness;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output brightness,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  brightness,
        output busy,
        output done
    );
endinterface

// File: rtl/apa102_frame_reader.sv
// APA102 frame reader: fetches pixels from the frame RAM read port and
// serialises start frame, one LED frame per pixel, and end frame on sck/sdo.
module apa102_frame_reader #(
    parameter int NUM_LEDS = 64,
    parameter int CLK_DIV  = 4,
    parameter int END_BITS = ((NUM_LEDS + 15) / 16) * 8,
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apa102_frame_reader_if.slave  ctl,
    output logic [AW-1:0]         raddr,
    input  logic [23:0]           read_data,
    output logic                  sck,
    output logic                  sdo
);

    typedef enum logic [1:0] {
        IDLE,
        START_FR,
        LED_FR,
        END_FR
    } state_t;

    localparam int MAXB = (END_BITS > 32) ? END_BITS : 32;
    localparam int BW   = $clog2(MAXB);
    localparam int LW   = $clog2(NUM_LEDS + 1);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] WORD_LAST = BW'(31);
    localparam logic [BW-1:0] END_LAST  = BW'(END_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LED_LAST  = LW'(NUM_LEDS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_LEDS - 1);

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [LW-1:0] led_cnt;
    logic [31:0]   shreg;
    logic [23:0]   hold;
    logic [4:0]    bri;
    logic [1:0]    fetch_cnt;
    logic [AW-1:0] raddr_q;
    logic          sck_q;
    logic          busy_q;
    logic          done_q;

    logic phase_end;
    logic bit_end;
    logic seg_end;
    logic accept;
    logic load_led;
    logic finish;

    assign phase_end = (div_cnt == DIV_LAST);
    assign bit_end   = phase_end & sck_q;
    assign seg_end   = bit_end &
        (bit_cnt == ((state == END_FR) ? END_LAST : WORD_LAST));

    assign raddr    = raddr_q;
    assign sck      = sck_q;
    assign sdo      = shreg[31];
    assign ctl.busy = busy_q;
    assign ctl.done = done_q;

    // Frame sequencing state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and segment-boundary strobes.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        load_led = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctl.start) begin
                    accept  = 1'b1;
                    state_n = START_FR;
                end
            end
            START_FR: begin
                if (seg_end) begin
                    load_led = 1'b1;
                    state_n  = LED_FR;
                end
            end
            LED_FR: begin
                if (seg_end) begin
                    if (led_cnt == LED_LAST) begin
                        state_n = END_FR;
                    end else begin
                        load_led = 1'b1;
                    end
                end
            end
            END_FR: begin
                if (seg_end) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timing, shifting, pixel prefetch and completion flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            bri       <= '0;
            fetch_cnt <= '0;
            raddr_q   <= '0;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fetch_cnt != 2'd0) begin
                fetch_cnt <= fetch_cnt - 2'd1;
            end
            // RAM data is valid two edges after raddr moved.
            if (fetch_cnt == 2'd1) begin
                hold <= read_data;
            end
            if (accept) begin
                busy_q    <= 1'b1;
                bri       <= ctl.brightness;
                raddr_q   <= '0;
                fetch_cnt <= 2'd3;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                led_cnt   <= '0;
                shreg     <= '0;
                sck_q     <= 1'b0;
            end else if (busy_q) begin
                if (!phase_end) begin
                    div_cnt <= div_cnt + DW'(1);
                end else begin
                    div_cnt <= '0;
                    sck_q   <= ~sck_q;
                    if (sck_q) begin
                        bit_cnt <= seg_end ? '0 : bit_cnt + BW'(1);
                        shreg   <= {shreg[30:0], 1'b0};
                        if (load_led) begin
                            shreg <= {3'b111, bri, hold[7:0],
                                      hold[15:8], hold[23:16]};
                            fetch_cnt <= 2'd3;
                            if (raddr_q != ADDR_LAST) begin
                                raddr_q <= raddr_q + AW'(1);
                            end
                            if (state == LED_FR) begin
                                led_cnt <= led_cnt + LW'(1);
                            end
                        end else if (state == LED_FR && seg_end) begin
                            shreg <= '1;
                        end
                        if (finish) begin
                            shreg  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
